// File: rtl/ysyx_24080006_trap_ctrl_if.sv
// Trap controller handshake bundle: request side from the pipeline and
// redirect side toward fetch.
interface ysyx_24080006_trap_ctrl_if;
    logic        exc_valid;
    logic [4:0]  exc_cause;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic        mret_valid;
    logic        exc_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    // Pipeline/fetch side
    modport master (
        output exc_valid, exc_cause, exc_pc, exc_tval, mret_valid, redirect_ready,
        input  exc_ready, redirect_valid, redirect_pc
    );

    // Trap controller side
    modport slave (
        input  exc_valid, exc_cause, exc_pc, exc_tval, mret_valid, redirect_ready,
        output exc_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ysyx_24080006_trap_ctrl.sv
// Trap/mret sequencer: accepts one request, drains the LSU (bounded by
// DRAIN_MAX), commits CSR side effects for one cycle, then holds a fetch
// redirect until fetch accepts it.
module ysyx_24080006_trap_ctrl #(
    parameter int unsigned DRAIN_MAX = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    ysyx_24080006_trap_ctrl_if.slave        tif,
    input  logic                            lsu_busy,
    input  logic [31:0]                     mtvec,
    input  logic [31:0]                     mepc,
    output logic                            flush,
    output logic                            csr_trap_we,
    output logic [31:0]                     csr_mepc,
    output logic [31:0]                     csr_mcause,
    output logic [31:0]                     csr_mtval,
    output logic                            csr_mret,
    output logic                            busy,
    output logic                            drain_timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_COMMIT,
        S_REDIRECT
    } state_t;

    // Counter value seen in the DRAIN_MAX-th drain cycle
    localparam logic [7:0] CNT_LAST = 8'(DRAIN_MAX - 1);

    state_t      state_q, state_d;
    logic        is_mret_q, is_mret_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic in_drain, drain_last;

    assign in_drain   = (state_q == S_DRAIN);
    assign drain_last = in_drain && (cnt_q == CNT_LAST);

    // Next-state and latched-payload logic
    always_comb begin
        state_d       = state_q;
        is_mret_d     = is_mret_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        mtval_d       = mtval_q;
        cnt_d         = cnt_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            S_IDLE: begin
                if (tif.exc_valid || tif.mret_valid) begin
                    // a trap takes priority over a simultaneous mret
                    is_mret_d = !tif.exc_valid;
                    mepc_d    = tif.exc_pc & 32'hFFFF_FFFE;
                    mcause_d  = {27'b0, tif.exc_cause};
                    mtval_d   = tif.exc_tval;
                    cnt_d     = 8'd0;
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 8'd1;
                if (!lsu_busy || drain_last) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                // target sampled from the CSR file in this cycle
                redirect_pc_d = is_mret_q ? (mepc & 32'hFFFF_FFFE)
                                          : (mtvec & 32'hFFFF_FFFC);
                state_d       = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (tif.redirect_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and payload registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            is_mret_q     <= 1'b0;
            mepc_q        <= 32'd0;
            mcause_q      <= 32'd0;
            mtval_q       <= 32'd0;
            cnt_q         <= 8'd0;
            redirect_pc_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            is_mret_q     <= is_mret_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mtval_q       <= mtval_d;
            cnt_q         <= cnt_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // Pulses are suppressed while reset is held so an aborted sequence emits nothing
    assign tif.exc_ready      = (state_q == S_IDLE) && !reset;
    assign tif.redirect_valid = (state_q == S_REDIRECT);
    assign tif.redirect_pc    = redirect_pc_q;
    assign flush              = in_drain && (cnt_q == 8'd0) && !reset;
    assign drain_timeout      = drain_last && lsu_busy && !reset;
    assign csr_trap_we        = (state_q == S_COMMIT) && !is_mret_q && !reset;
    assign csr_mret           = (state_q == S_COMMIT) && is_mret_q && !reset;
    assign csr_mepc           = mepc_q;
    assign csr_mcause         = mcause_q;
    assign csr_mtval          = mtval_q;
    assign busy               = (state_q != S_IDLE);

endmodule

// File: tb/tb_ysyx_24080006_trap_ctrl.sv
// Bench for the trap controller: directed vector table, random transactions
// against a transaction-level model, and reset-abort sequences.
module tb_ysyx_24080006_trap_ctrl;

    localparam int DMAX = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        lsu_busy;
    logic [31:0] mtvec, mepc;
    logic        flush, csr_trap_we, csr_mret, busy, drain_timeout;
    logic [31:0] csr_mepc, csr_mcause, csr_mtval;

    int checks = 0;
    int errors = 0;

    ysyx_24080006_trap_ctrl_if tif();

    ysyx_24080006_trap_ctrl #(.DRAIN_MAX(DMAX)) dut (
        .clock         (clock),
        .reset         (reset),
        .tif           (tif),
        .lsu_busy      (lsu_busy),
        .mtvec         (mtvec),
        .mepc          (mepc),
        .flush         (flush),
        .csr_trap_we   (csr_trap_we),
        .csr_mepc      (csr_mepc),
        .csr_mcause    (csr_mcause),
        .csr_mtval     (csr_mtval),
        .csr_mret      (csr_mret),
        .busy          (busy),
        .drain_timeout (drain_timeout)
    );

    always #5 clock = ~clock;

    // kind: 0 = trap, 1 = mret, 2 = both raised together
    typedef struct {
        int          kind;
        logic [4:0]  cause;
        logic [31:0] pc;
        logic [31:0] tval;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        int          busy_len;
        int          delay;
        logic [31:0] e_mcause;
        logic [31:0] e_mepc;
        logic [31:0] e_target;
        int          e_drain;
        bit          e_timeout;
    } vec_t;

    task automatic chk(input string nm, input int id, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec%0d cyc%0d %s: got %h expected %h", id, k, nm, act, exp);
        end
    endtask

    // Transaction-level reference: outcome of one request from its parameters
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.e_mcause  = 32'(v.cause);
        r.e_mepc    = v.pc - (v.pc % 2);
        r.e_target  = (v.kind != 1) ? (v.mtvec - (v.mtvec % 4)) : (v.mepc - (v.mepc % 2));
        r.e_timeout = (v.busy_len >= DMAX);
        r.e_drain   = r.e_timeout ? DMAX : v.busy_len + 1;
        return r;
    endfunction

    task automatic idle_cycles(input int n, input int id);
        for (int i = 0; i < n; i++) begin
            tif.exc_valid  = 1'b0;
            tif.mret_valid = 1'b0;
            lsu_busy       = 1'($urandom_range(0, 1));
            @(negedge clock);
            chk("idle_exc_ready", id, i, 32'(tif.exc_ready), 32'd1);
            chk("idle_busy", id, i, 32'(busy), 32'd0);
            chk("idle_redirect_valid", id, i, 32'(tif.redirect_valid), 32'd0);
            chk("idle_pulses", id, i, {28'd0, flush, csr_trap_we, csr_mret, drain_timeout}, 32'd0);
            @(posedge clock); #1;
        end
    endtask

    // Apply one request starting in IDLE and check every cycle until the return to IDLE
    task automatic run_txn(input vec_t v, input int id);
        bit trap = (v.kind != 1);
        int commit_k = v.e_drain + 1;
        int rv_first = v.e_drain + 2;
        int last = v.e_drain + v.delay + 2;
        int rv_seen = 0;
        for (int k = 0; k <= last; k++) begin
            if (k == 0) begin
                tif.exc_valid  = (v.kind != 1);
                tif.mret_valid = (v.kind != 0);
                tif.exc_cause  = v.cause;
                tif.exc_pc     = v.pc;
                tif.exc_tval   = v.tval;
            end else begin
                // junk requests while busy must be ignored; the return edge gets a live one
                tif.exc_valid  = (k == last) ? 1'b1 : 1'($urandom_range(0, 1));
                tif.mret_valid = 1'($urandom_range(0, 1));
                tif.exc_cause  = 5'($urandom);
                tif.exc_pc     = $urandom;
                tif.exc_tval   = $urandom;
            end
            lsu_busy           = (k <= v.busy_len);
            mtvec              = (k == commit_k) ? v.mtvec : $urandom;
            mepc               = (k == commit_k) ? v.mepc : $urandom;
            tif.redirect_ready = (rv_seen >= v.delay);
            @(negedge clock);
            chk("exc_ready", id, k, 32'(tif.exc_ready), 32'(k == 0));
            chk("busy", id, k, 32'(busy), 32'(k != 0));
            chk("flush", id, k, 32'(flush), 32'(k == 1));
            chk("drain_timeout", id, k, 32'(drain_timeout), 32'(v.e_timeout && k == DMAX));
            chk("csr_trap_we", id, k, 32'(csr_trap_we), 32'(trap && k == commit_k));
            chk("csr_mret", id, k, 32'(csr_mret), 32'(!trap && k == commit_k));
            chk("redirect_valid", id, k, 32'(tif.redirect_valid), 32'(k >= rv_first));
            if (k >= rv_first)
                chk("redirect_pc", id, k, tif.redirect_pc, v.e_target);
            if (trap && k == commit_k) begin
                chk("csr_mepc", id, k, csr_mepc, v.e_mepc);
                chk("csr_mcause", id, k, csr_mcause, v.e_mcause);
                chk("csr_mtval", id, k, csr_mtval, v.tval);
            end
            if (tif.redirect_valid) rv_seen++;
            @(posedge clock); #1;
        end
        tif.exc_valid  = 1'b0;
        tif.mret_valid = 1'b0;
    endtask

    // Start a trap with lsu held busy and fetch stalled, then reset at cycle at_k
    task automatic reset_abort(input int at_k, input int id);
        for (int k = 0; k <= at_k; k++) begin
            tif.exc_valid      = (k == 0);
            tif.mret_valid     = 1'b0;
            tif.exc_cause      = 5'd4;
            tif.exc_pc         = 32'h8000_0040;
            tif.exc_tval       = 32'h1234_5678;
            lsu_busy           = (at_k < 5) ? 1'b1 : 1'b0;
            mtvec              = 32'h8000_0800;
            mepc               = 32'h0;
            tif.redirect_ready = 1'b0;
            reset              = (k == at_k);
            @(negedge clock);
            if (k == at_k)
                chk("rst_exc_ready_low", id, k, 32'(tif.exc_ready), 32'd0);
            @(posedge clock); #1;
        end
        reset = 1'b0;
        @(negedge clock);
        chk("rst_exc_ready", id, 99, 32'(tif.exc_ready), 32'd1);
        chk("rst_busy", id, 99, 32'(busy), 32'd0);
        chk("rst_pulses", id, 99, {27'd0, flush, csr_trap_we, csr_mret, drain_timeout, tif.redirect_valid}, 32'd0);
        chk("rst_redirect_pc", id, 99, tif.redirect_pc, 32'd0);
        chk("rst_csr_mepc", id, 99, csr_mepc, 32'd0);
        chk("rst_csr_mcause", id, 99, csr_mcause, 32'd0);
        chk("rst_csr_mtval", id, 99, csr_mtval, 32'd0);
        @(posedge clock); #1;
    endtask

    vec_t vecs[10];

    initial begin
        //         kind cause  pc            tval          mtvec         mepc          busy dly  mcause        mepc          target        drain tmo
        vecs[0] = '{0, 5'd11, 32'h8000_0104, 32'h0,        32'h8000_0A01, 32'h0,        0,  0, 32'd11,       32'h8000_0104, 32'h8000_0A00, 1,  0};
        vecs[1] = '{1, 5'd0,  32'h1234_5679, 32'h0,        32'h0,        32'h8000_0107, 0,  0, 32'd0,        32'h1234_5678, 32'h8000_0106, 1,  0};
        vecs[2] = '{2, 5'd2,  32'h8000_0200, 32'hDEAD_BEEF, 32'h8000_1000, 32'h5555_5555, 0,  0, 32'd2,        32'h8000_0200, 32'h8000_1000, 1,  0};
        vecs[3] = '{0, 5'd5,  32'h8000_0003, 32'h0000_0AAA, 32'h8000_0004, 32'h0,        40, 0, 32'd5,        32'h8000_0002, 32'h8000_0004, 16, 1};
        vecs[4] = '{0, 5'd7,  32'h8000_0010, 32'h0,        32'h8000_0103, 32'h0,        5,  0, 32'd7,        32'h8000_0010, 32'h8000_0100, 6,  0};
        vecs[5] = '{1, 5'd3,  32'h0,        32'h0,        32'h0,        32'h0000_0FFF, 0,  7, 32'd3,        32'h0,        32'h0000_0FFE, 1,  0};
        vecs[6] = '{0, 5'd1,  32'h0000_1000, 32'h1,        32'h0000_2000, 32'h0,        15, 1, 32'd1,        32'h0000_1000, 32'h0000_2000, 16, 0};
        vecs[7] = '{0, 5'd1,  32'h0000_1000, 32'h2,        32'h0000_2000, 32'h0,        16, 2, 32'd1,        32'h0000_1000, 32'h0000_2000, 16, 1};
        vecs[8] = '{0, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,        1,  0, 32'h1F,       32'hFFFF_FFFE, 32'hFFFF_FFFC, 2,  0};
        vecs[9] = '{1, 5'd9,  32'h0,        32'h0,        32'h0,        32'h8000_0000, 3,  3, 32'd9,        32'h0,        32'h8000_0000, 4,  0};

        reset = 1'b1;
        lsu_busy = 1'b0;
        mtvec = 32'h0;
        mepc = 32'h0;
        tif.exc_valid = 1'b1;
        tif.mret_valid = 1'b1;
        tif.exc_cause = 5'd11;
        tif.exc_pc = 32'h8000_0000;
        tif.exc_tval = 32'h0;
        tif.redirect_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("in_reset_exc_ready", -1, i, 32'(tif.exc_ready), 32'd0);
            @(posedge clock); #1;
        end
        reset = 1'b0;
        tif.exc_valid = 1'b0;
        tif.mret_valid = 1'b0;
        @(negedge clock);
        chk("post_reset_exc_ready", -1, 0, 32'(tif.exc_ready), 32'd1);
        chk("post_reset_busy", -1, 0, 32'(busy), 32'd0);
        chk("post_reset_pulses", -1, 0, {27'd0, flush, csr_trap_we, csr_mret, drain_timeout, tif.redirect_valid}, 32'd0);
        chk("post_reset_redirect_pc", -1, 0, tif.redirect_pc, 32'd0);
        chk("post_reset_csr", -1, 0, csr_mepc | csr_mcause | csr_mtval, 32'd0);
        @(posedge clock); #1;

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i], i);
            if (i % 3 == 1) idle_cycles(2, i);
        end

        for (int i = 0; i < 40; i++) begin
            vec_t r;
            r.kind     = $urandom_range(0, 2);
            r.cause    = 5'($urandom);
            r.pc       = $urandom;
            r.tval     = $urandom;
            r.mtvec    = $urandom;
            r.mepc     = $urandom;
            r.busy_len = $urandom_range(0, 20);
            r.delay    = $urandom_range(0, 4);
            r = model(r);
            run_txn(r, 100 + i);
            idle_cycles($urandom_range(0, 2), 100 + i);
        end

        reset_abort(3, 200);
        reset_abort(6, 201);
        run_txn(vecs[0], 202);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_24080006_trap_ctrl.md
YSYX_24080006_TRAP_CTRL -- requirements
Module: ysyx_24080006_trap_ctrl

Interface
REQ-001 Parameter DRAIN_MAX, default 16, meaning max DRAIN cycles before forced commit; legal range 2..255.
REQ-002 Reset is reset, synchronous, active-high; clock is clock.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 exc_valid  in  1  pipeline reports a synchronous exception.
REQ-006 exc_cause  in  5  exception code (ecall-M = 11).
REQ-007 exc_pc  in  32  PC of the faulting instruction.
REQ-008 exc_tval  in  32  trap value.
REQ-009 mret_valid  in  1  pipeline reports an mret.
REQ-010 exc_ready  out  1  request accepted when high.
REQ-011 lsu_busy  in  1  memory transaction outstanding.
REQ-012 mtvec  in  32  current mtvec from the CSR file.
REQ-013 mepc  in  32  current mepc from the CSR file.
REQ-014 flush  out  1  one-cycle pipeline flush pulse.
REQ-015 csr_trap_we  out  1  one-cycle pulse; the CSR file loads mepc/mcause/mtval and updates mstatus for trap entry.
REQ-016 csr_mepc, csr_mcause, csr_mtval  out  32 each  values loaded on csr_trap_we.
REQ-017 csr_mret  out  1  one-cycle pulse; the CSR file performs the mstatus mret update.
REQ-018 redirect_valid  out  1  new PC is available.
REQ-019 redirect_pc  out  32  fetch target.
REQ-020 redirect_ready  in  1  fetch accepts the redirect.
REQ-021 busy  out  1  high in any state other than IDLE.
REQ-022 drain_timeout  out  1  one-cycle pulse when the drain is forced.

Function
REQ-023 FSM states: IDLE, DRAIN, COMMIT, REDIRECT. exc_ready SHALL equal (state==IDLE).
REQ-024 Accept: on an edge where state is IDLE and either exc_valid or mret_valid is high.
  - Latch kind (trap/mret).
  - Latch mepc value {exc_pc[31:1],1'b0}.
  - Latch mcause value {27'b0, exc_cause}, with bit31 = 0.
  - Latch exc_tval.
  - Go to DRAIN.
REQ-025 If exc_valid and mret_valid are high together, the trap SHALL win and the mret SHALL be discarded.
REQ-026 flush SHALL be high only in the first DRAIN cycle.
REQ-027 DRAIN exits to COMMIT on any edge where lsu_busy==0, including the first DRAIN cycle.
REQ-028 An 8-bit counter SHALL count DRAIN cycles.
  - If lsu_busy is still 1 in the DRAIN_MAX-th DRAIN cycle, go to COMMIT.
  - drain_timeout SHALL pulse in that cycle.
  - The counter SHALL clear on DRAIN entry.
REQ-029 COMMIT lasts exactly one cycle.
  - Trap: csr_trap_we=1; target = {mtvec[31:2],2'b00}, sampled in COMMIT.
  - mret: csr_mret=1; target = {mepc[31:1],1'b0}, sampled in COMMIT.
  - Both cases: go to REDIRECT.
REQ-030 csr_mepc, csr_mcause and csr_mtval SHALL present the latched values whenever csr_trap_we is high.
REQ-031 REDIRECT: hold redirect_valid=1 with a stable redirect_pc until redirect_ready; on that edge go to IDLE.
REQ-032 In IDLE, redirect_valid=0.
REQ-033 The edge that returns to IDLE SHALL NOT accept a new request; acceptance resumes one cycle later.
REQ-034 Minimum latency, accept edge to redirect_valid: 3 cycles (DRAIN, COMMIT, REDIRECT), with lsu_busy=0 and redirect_ready=1.
REQ-035 exc_valid and mret_valid outside IDLE SHALL be ignored; the pipeline holds them until exc_ready.
REQ-036 flush, csr_trap_we, csr_mret and drain_timeout SHALL never be high in the same cycle as one another.

Reset
REQ-037 Reset SHALL force state IDLE from any state, including mid-DRAIN and mid-REDIRECT, with no pulses generated.
REQ-038 Output values after reset:
  - flush, csr_trap_we, csr_mret, redirect_valid, busy and drain_timeout = 0.
  - redirect_pc, csr_mepc, csr_mcause and csr_mtval = 0.
  - exc_ready = 1 in the first cycle after reset deasserts.
REQ-039 While reset is high, exc_ready=0 and no request SHALL be accepted.

Verification
REQ-040 ecall: exc_cause=11, exc_pc=0x8000_0104, mtvec=0x8000_0A01, lsu_busy=0, redirect_ready=1 -> flush at cycle+1; csr_trap_we at +2 with csr_mepc=0x8000_0104 and csr_mcause=11; redirect_pc=0x8000_0A00 at +3; IDLE at +4.
REQ-041 mret: mepc=0x8000_0107 -> csr_mret at +2, redirect_pc=0x8000_0106, csr_trap_we never asserted.
REQ-042 Simultaneous exc_valid (cause 2) and mret_valid -> exactly one trap sequence, csr_mcause=2, csr_mret never asserted.
REQ-043 DRAIN_MAX=16, lsu_busy held at 1 -> 16 DRAIN cycles, drain_timeout pulse in the 16th, then COMMIT.
  - Separate run, lsu_busy falling after 5 cycles -> COMMIT on the 6th cycle, no timeout.
REQ-044 redirect_ready held at 0 for 7 cycles -> redirect_valid and redirect_pc stable for 8 cycles, exc_ready=0 throughout.
  - Separate run, reset asserted in DRAIN -> next cycle all outputs at reset values, exc_ready=1.
